tt_um_btflv_8bit_int_to_fp_encoder: RTL

- Producer side of the team's 8-bit float format `{sign, exp[3:0], mant[2:0]}`, where value = 1.mmm × 2^exp. The existing fp adder consumes this format.
- Converts a signed 8-bit two's-complement integer on `ui_in` into that format.
- Uses an iterative one-bit-per-cycle normalizer behind a start/busy/done handshake on the `uio` pins.
- Same TinyTapeout wrapper port set as the adder, so its `uo_out` can feed adder operands directly.

---
 rtl/fp8_pkg.sv | 35 +++
 rtl/fp8_pack.sv | 38 +++
 rtl/tt_um_btflv_8bit_int_to_fp_encoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fp8_pkg.sv
// Shared definitions for the 8-bit float format {sign, exp[3:0], mant[2:0]}.
// The encoder and the adder both use this package.
package fp8_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 4;
    localparam int unsigned MANT_W = 3;
    localparam int unsigned FP_W   = SIGN_W + EXP_W + MANT_W;

    localparam int unsigned SIGN_POS = FP_W - 1;
    localparam int unsigned EXP_LSB  = MANT_W;
    localparam int unsigned EXP_MSB  = MANT_W + EXP_W - 1;
    localparam int unsigned MANT_LSB = 0;
    localparam int unsigned MANT_MSB = MANT_W - 1;

    localparam int unsigned UIO_START   = 0;
    localparam int unsigned UIO_BUSY    = 1;
    localparam int unsigned UIO_DONE    = 2;
    localparam int unsigned UIO_INEXACT = 3;
    localparam int unsigned UIO_ZERO    = 4;

    localparam logic [7:0] UIO_OE = 8'b0001_1110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_NORM = 1'b1
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp8_t;

endpackage

// File: rtl/fp8_pack.sv
// Packs a normalized magnitude (mag[7]=1) with its exponent and sign into fp8,
// optionally rounding half-up on the magnitude.
module fp8_pack
    import fp8_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b0
) (
    input  logic [7:0]       mag,
    input  logic [EXP_W-1:0] exp,
    input  logic             sign,
    output logic [FP_W-1:0]  fp_c,
    output logic             inexact_c
);

    localparam int unsigned MANT_RW = MANT_W + 1;

    logic [3:0]         rem;
    logic               round_up;
    logic [MANT_RW-1:0] mant_r;
    fp8_t               res;
    logic               unused_ok;

    // Hidden bit is implied by normalization and not stored.
    assign unused_ok = mag[7];

    always_comb begin
        rem       = mag[3:0];
        inexact_c = |rem;
        round_up  = ROUND_NEAREST && rem[3];
        mant_r    = {1'b0, mag[6:4]} + MANT_RW'(round_up);
        res.sign  = sign;
        // Mantissa carry renormalizes to 1.000 at the next exponent.
        res.exp   = mant_r[MANT_W] ? exp + EXP_W'(1) : exp;
        res.mant  = mant_r[MANT_W-1:0];
        fp_c      = res;
    end

endmodule

// File: rtl/tt_um_btflv_8bit_int_to_fp_encoder.sv
// Signed 8-bit integer to fp8 encoder: iterative one-bit-per-cycle normalizer
// behind a start/busy/done handshake on the uio pins.
module tt_um_btflv_8bit_int_to_fp_encoder
    import fp8_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b0
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic [7:0]       mag_q, mag_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [7:0]       uo_q, uo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             inexact_q, inexact_d;
    logic             zero_q, zero_d;

    logic             start;
    logic             finish_c;
    logic [FP_W-1:0]  packed_c;
    logic             pack_inexact_c;
    logic             unused_ok;

    assign start     = uio_in[UIO_START];
    assign unused_ok = &{1'b1, uio_in[7:1]};
    assign finish_c  = (mag_q == 8'd0) || mag_q[7];

    fp8_pack #(
        .ROUND_NEAREST(ROUND_NEAREST)
    ) u_pack (
        .mag      (mag_q),
        .exp      (exp_q),
        .sign     (sign_q),
        .fp_c     (packed_c),
        .inexact_c(pack_inexact_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                ST_IDLE: if (start) state_d = ST_NORM;
                ST_NORM: if (finish_c) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered output next values
    always_comb begin
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        uo_d      = uo_q;
        busy_d    = busy_q;
        done_d    = done_q;
        inexact_d = inexact_q;
        zero_d    = zero_q;
        if (ena) begin
            done_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sign_d = ui_in[7];
                        mag_d  = ui_in[7] ? 8'(-ui_in) : ui_in;
                        exp_d  = EXP_W'(7);
                        busy_d = 1'b1;
                    end
                end
                ST_NORM: begin
                    if (mag_q == 8'd0) begin
                        uo_d      = 8'h00;
                        zero_d    = 1'b1;
                        inexact_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else if (mag_q[7]) begin
                        uo_d      = packed_c;
                        zero_d    = 1'b0;
                        inexact_d = pack_inexact_c;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        mag_d = mag_q << 1;
                        exp_d = exp_q - EXP_W'(1);
                    end
                end
                default: busy_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q    <= 1'b0;
            mag_q     <= 8'd0;
            exp_q     <= '0;
            uo_q      <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inexact_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            uo_q      <= uo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            inexact_q <= inexact_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        uio_out              = 8'h00;
        uio_out[UIO_BUSY]    = busy_q;
        uio_out[UIO_DONE]    = done_q;
        uio_out[UIO_INEXACT] = inexact_q;
        uio_out[UIO_ZERO]    = zero_q;
    end

    assign uo_out = uo_q;
    assign uio_oe = UIO_OE;

endmodule
